dmem_lane_arbiter: RTL and testbench

- Shares the single data-memory port between the two issue lanes of the dual-issue core.
- Each lane may present one load or store per bundle in the X stage. Requests are serialised in program order: lane 1 first, then lane 2.
- Holds the pipeline with `stall` while a memory access is pending.
- Returns load data to each lane's writeback mux.
- Sits between the X-stage lane logic and the data-memory macro. The memory has a valid/ready request channel and an rvalid response channel with variable latency.

---
 rtl/riscv_core_pkg.sv | 21 ++
 rtl/lane_req_reg.sv | 47 ++++
 rtl/dmem_lane_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_dmem_lane_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_core_pkg.sv
// Shared core types: data-memory arbiter states, datamem flags, NOP.
// Imported by the dmem_lane_arbiter slice.
package riscv_core_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISS1,
    WT1,
    ISS2,
    WT2,
    DONE
  } arb_state_t;

  localparam logic [2:0] DM_BYTE     = 3'b000;
  localparam logic [2:0] DM_HALF     = 3'b001;
  localparam logic [2:0] DM_WORD     = 3'b010;
  localparam logic [2:0] DM_UNSIGNED = 3'b100;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/lane_req_reg.sv
// Per-lane capture of {write, addr, wdata, flags} for the dmem arbiter.
// Loaded when the arbiter leaves IDLE; holds the access while issuing.
module lane_req_reg
  import riscv_core_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_ld,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [2:0]        i_flags,
  output logic              o_write,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  output logic [2:0]        o_flags
);

  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [2:0]        r_flags;

  // capture the lane's access fields on load enable
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_flags <= DM_BYTE;
    end else if (i_ld) begin
      r_write <= i_write;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
      r_flags <= i_flags;
    end
  end

  assign o_write = r_write;
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;
  assign o_flags = r_flags;

endmodule

// File: rtl/dmem_lane_arbiter.sv
// Serialises lane 1 then lane 2 loads/stores onto one dmem port.
// Optional perf counters: define DMEM_ARB_PERF_EN.
module dmem_lane_arbiter
  import riscv_core_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic [2:0]        req1_flags,
  input  logic              req2_valid,
  input  logic              req2_write,
  input  logic [ADDR_W-1:0] req2_addr,
  input  logic [DATA_W-1:0] req2_wdata,
  input  logic [2:0]        req2_flags,
  input  logic              kill2,
  output logic              stall,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_rdata,
  output logic              resp2_valid,
  output logic [DATA_W-1:0] resp2_rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_flags,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_dual_bundles
`endif
);

  localparam int CW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [31:0] TO_LAST =
    (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  arb_state_t r_state;
  arb_state_t w_nxt;

  logic              w_l2eff;
  logic              w_ld;
  logic              w_wait;
  logic              w_to;
  logic [CW-1:0]     r_cnt;
  logic              r_did1;
  logic              r_did2;
  logic [DATA_W-1:0] r_rdata1;
  logic [DATA_W-1:0] r_rdata2;
  logic              r_err;

  logic              w_l1_write;
  logic [ADDR_W-1:0] w_l1_addr;
  logic [DATA_W-1:0] w_l1_wdata;
  logic [2:0]        w_l1_flags;
  logic              w_l2_write;
  logic [ADDR_W-1:0] w_l2_addr;
  logic [DATA_W-1:0] w_l2_wdata;
  logic [2:0]        w_l2_flags;

  assign w_l2eff = req2_valid && !kill2;
  assign w_ld    = (r_state == IDLE) && (w_nxt != IDLE);
  assign w_wait  = (r_state == WT1) || (r_state == WT2);
  assign w_to    = TO_EN && w_wait && !mem_rvalid &&
                   (32'(r_cnt) >= TO_LAST);

  lane_req_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_lane1 (
    .clock   (clock),
    .reset   (reset),
    .i_ld    (w_ld),
    .i_write (req1_write),
    .i_addr  (req1_addr),
    .i_wdata (req1_wdata),
    .i_flags (req1_flags),
    .o_write (w_l1_write),
    .o_addr  (w_l1_addr),
    .o_wdata (w_l1_wdata),
    .o_flags (w_l1_flags)
  );

  lane_req_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_lane2 (
    .clock   (clock),
    .reset   (reset),
    .i_ld    (w_ld),
    .i_write (req2_write),
    .i_addr  (req2_addr),
    .i_wdata (req2_wdata),
    .i_flags (req2_flags),
    .o_write (w_l2_write),
    .o_addr  (w_l2_addr),
    .o_wdata (w_l2_wdata),
    .o_flags (w_l2_flags)
  );

  // next-state: lane 1 first, lane 2 only if still effective
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (req1_valid)   w_nxt = ISS1;
        else if (w_l2eff) w_nxt = ISS2;
      end
      ISS1: if (mem_ready) w_nxt = WT1;
      WT1: begin
        if (mem_rvalid) w_nxt = w_l2eff ? ISS2 : DONE;
        else if (w_to)  w_nxt = DONE;
      end
      ISS2: if (mem_ready) w_nxt = WT2;
      WT2:  if (mem_rvalid || w_to) w_nxt = DONE;
      DONE: w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // memory request and pipeline-facing outputs
  always_comb begin
    stall = (r_state != DONE) &&
            (req1_valid || w_l2eff || (r_state != IDLE));
    mem_req   = (r_state == ISS1) || (r_state == ISS2);
    mem_write = ((r_state == ISS1) && w_l1_write) ||
                ((r_state == ISS2) && w_l2_write);
    mem_addr  = w_l1_addr;
    mem_wdata = w_l1_wdata;
    mem_flags = w_l1_flags;
    if (r_state == ISS2) begin
      mem_addr  = w_l2_addr;
      mem_wdata = w_l2_wdata;
      mem_flags = w_l2_flags;
    end
    resp1_valid = (r_state == DONE) && r_did1 && !w_l1_write;
    resp2_valid = (r_state == DONE) && r_did2 && !w_l2_write;
  end

  // state, wait counter, lane bookkeeping, load data and error
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_did1   <= 1'b0;
      r_did2   <= 1'b0;
      r_rdata1 <= '0;
      r_rdata2 <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_nxt != r_state)
        r_cnt <= '0;
      else if (r_cnt != {CW{1'b1}})
        r_cnt <= r_cnt + CW'(1);
      if (w_ld) begin
        r_did1 <= req1_valid;
        r_did2 <= !req1_valid;
      end
      if ((r_state == WT1) && (w_nxt == ISS2))
        r_did2 <= 1'b1;
      if ((r_state == WT1) && mem_rvalid && !w_l1_write)
        r_rdata1 <= mem_rdata;
      if ((r_state == WT1) && w_to)
        r_rdata1 <= '0;
      if ((r_state == WT2) && mem_rvalid && !w_l2_write)
        r_rdata2 <= mem_rdata;
      if ((r_state == WT2) && w_to)
        r_rdata2 <= '0;
      if (w_to)
        r_err <= 1'b1;
    end
  end

  assign resp1_rdata = r_rdata1;
  assign resp2_rdata = r_rdata2;
  assign err         = r_err;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_dual;

  // stall-cycle and dual-access bundle counters, wrapping
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_perf_stall <= '0;
      r_perf_dual  <= '0;
    end else begin
      if (stall)
        r_perf_stall <= r_perf_stall + 32'd1;
      if ((r_state == DONE) && r_did1 && r_did2)
        r_perf_dual <= r_perf_dual + 32'd1;
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_dual_bundles = r_perf_dual;
`endif

endmodule

// File: tb/tb_dmem_lane_arbiter.sv
// Randomised bench for dmem_lane_arbiter against a bundle-level model.
// Memory responder and expected results live in the bench.
module tb_dmem_lane_arbiter;
  import riscv_core_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          req1_valid, req1_write;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic [2:0]    req1_flags;
  logic          req2_valid, req2_write;
  logic [AW-1:0] req2_addr;
  logic [DW-1:0] req2_wdata;
  logic [2:0]    req2_flags;
  logic          kill2;
  logic          stall;
  logic          resp1_valid, resp2_valid;
  logic [DW-1:0] resp1_rdata, resp2_rdata;
  logic          err;
  logic          mem_req, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    mem_flags;
  logic          mem_ready, mem_rvalid;
  logic [DW-1:0] mem_rdata;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0]   perf_s, perf_d;
`endif

  always #5 clock = ~clock;

  dmem_lane_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock (clock), .reset (reset),
    .req1_valid (req1_valid), .req1_write (req1_write),
    .req1_addr (req1_addr), .req1_wdata (req1_wdata),
    .req1_flags (req1_flags),
    .req2_valid (req2_valid), .req2_write (req2_write),
    .req2_addr (req2_addr), .req2_wdata (req2_wdata),
    .req2_flags (req2_flags),
    .kill2 (kill2), .stall (stall),
    .resp1_valid (resp1_valid), .resp1_rdata (resp1_rdata),
    .resp2_valid (resp2_valid), .resp2_rdata (resp2_rdata),
    .err (err),
    .mem_req (mem_req), .mem_write (mem_write),
    .mem_addr (mem_addr), .mem_wdata (mem_wdata),
    .mem_flags (mem_flags),
    .mem_ready (mem_ready), .mem_rvalid (mem_rvalid),
    .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_stall_cycles (perf_s),
    .perf_dual_bundles (perf_d)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;
  logic exp_err = 1'b0;

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] dev_mem [logic [31:0]];

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f;
    int          lane;
    int          wr;
    int          lat;
  } op_t;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] dev_rd(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : 32'h0;
  endfunction

  task automatic idle_inputs();
    req1_valid = 0; req1_write = 0; req1_addr = 0;
    req1_wdata = 0; req1_flags = 0;
    req2_valid = 0; req2_write = 0; req2_addr = 0;
    req2_wdata = 0; req2_flags = 0;
    kill2 = 0; mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1;
    exp_err = 1'b0;
  endtask

  // wr: ready-wait cycles (-1 random); lat: rvalid delay (-1 random, -2 never)
  task automatic run_bundle(
    input logic v1, input logic w1, input logic [31:0] a1,
    input logic [31:0] d1, input logic [2:0] f1,
    input logic v2, input logic w2, input logic [31:0] a2,
    input logic [31:0] d2, input logic [2:0] f2,
    input logic k2,
    input int wr1, input int lt1, input int wr2, input int lt2);
    op_t q[$];
    op_t o;
    int exp_stall = 0, stall_n = 0, nreq = 0, exp_n;
    int r1n = 0, r2n = 0, e1 = 0, e2 = 0;
    logic [31:0] r1d = 0, r2d = 0, e1d = 0, e2d = 0;
    bit pend = 0, pend_next = 0, present = 0, fin = 0;
    int wleft = 0, lleft = 0;
    logic [31:0] paddr = 0;
    logic pw = 0;
    if (v1) begin
      o = '{w1, a1, d1, f1, 1, wr1, lt1};
      q.push_back(o);
    end
    if (v2 && !k2) begin
      o = '{w2, a2, d2, f2, 2, wr2, lt2};
      q.push_back(o);
    end
    foreach (q[i]) begin
      if (q[i].wr < 0) q[i].wr = int'($urandom_range(0, 2));
      if (q[i].lat == -1) q[i].lat = int'($urandom_range(0, 4));
      exp_stall += 1 + q[i].wr + ((q[i].lat < 0) ? TO : q[i].lat + 1);
      if (q[i].lat < 0) begin
        exp_err = 1'b1;
        if (q[i].lane == 1) begin e1 = q[i].w ? 0 : 1; e1d = 0; end
        else begin e2 = q[i].w ? 0 : 1; e2d = 0; end
      end else if (q[i].w) begin
        ref_mem[q[i].a] = q[i].d;
      end else if (q[i].lane == 1) begin
        e1 = 1; e1d = ref_rd(q[i].a);
      end else begin
        e2 = 1; e2d = ref_rd(q[i].a);
      end
    end
    if (q.size() > 0) exp_stall += 1;
    exp_n = q.size();
    req1_valid = v1; req1_write = w1; req1_addr = a1;
    req1_wdata = d1; req1_flags = f1;
    req2_valid = v2; req2_write = w2; req2_addr = a2;
    req2_wdata = d2; req2_flags = f2;
    kill2 = k2;
    #1;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      if (stall) stall_n++;
      if (resp1_valid) begin r1n++; r1d = resp1_rdata; end
      if (resp2_valid) begin r2n++; r2d = resp2_rdata; end
      mem_ready = 0; mem_rvalid = 0; mem_rdata = $urandom;
      if (pend_next) begin pend = 1; pend_next = 0; end
      if (pend) begin
        if (lleft == 0) begin
          mem_rvalid = 1;
          mem_rdata = pw ? $urandom : dev_rd(paddr);
          pend = 0;
        end else if (lleft > 0) begin
          lleft--;
        end
      end
      if (mem_req) begin
        if (q.size() == 0) begin
          chk("extra_req", 128'(1), 128'(0));
          mem_ready = 1; pw = mem_write; paddr = mem_addr;
          lleft = 0; pend_next = 1;
        end else begin
          if (!present) begin present = 1; wleft = q[0].wr; end
          chk("mem_op",
              128'({mem_write, mem_addr, mem_wdata, mem_flags}),
              128'({q[0].w, q[0].a, q[0].d, q[0].f}));
          if (wleft > 0) begin
            wleft--;
          end else begin
            mem_ready = 1;
            if (mem_write) dev_mem[mem_addr] = mem_wdata;
            pw = mem_write; paddr = mem_addr;
            lleft = q[0].lat; pend_next = 1; present = 0;
            nreq++;
            void'(q.pop_front());
          end
        end
      end
      if (!stall) fin = 1;
      else begin @(posedge clock); #1; end
    end
    if (!fin) begin
      chk("bundle_hang", 128'(0), 128'(1));
      do_reset();
    end
    chk("stall_cycles", 128'(stall_n), 128'(exp_stall));
    chk("n_mem_req", 128'(nreq), 128'(exp_n));
    chk("resp1_pulses", 128'(r1n), 128'(e1));
    if (e1 != 0) chk("resp1_rdata", 128'(r1d), 128'(e1d));
    chk("resp2_pulses", 128'(r2n), 128'(e2));
    if (e2 != 0) chk("resp2_rdata", 128'(r2d), 128'(e2d));
    chk("err", 128'(err), 128'(exp_err));
    idle_inputs();
    @(posedge clock); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic v1, v2, w1, w2, k2;
    logic [31:0] a1, a2;
    do_reset();
    chk("rst_stall", 128'(stall), 128'(0));
    chk("rst_mem_req", 128'(mem_req), 128'(0));
    chk("rst_resp", 128'({resp1_valid, resp2_valid}), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_rdata", 128'({resp1_rdata, resp2_rdata}), 128'(0));

    ref_mem[32'h100] = 32'hDEAD_BEEF;
    dev_mem[32'h100] = 32'hDEAD_BEEF;
    run_bundle(1, 0, 32'h100, 0, DM_WORD, 0, 0, 0, 0, 0, 0,
               0, 0, 0, 0);
    run_bundle(1, 1, 32'h200, 32'h11, DM_WORD,
               1, 0, 32'h200, 0, DM_WORD, 0, 0, 0, 0, 0);
    run_bundle(1, 0, 32'h100, 0, DM_HALF,
               1, 1, 32'h104, 32'h55, DM_BYTE, 1, 0, 0, 0, 0);
    run_bundle(1, 1, 32'h108, 32'hA5A5_0001, DM_BYTE,
               0, 0, 0, 0, 0, 0, 4, -1, 0, 0);
    run_bundle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_bundle(0, 0, 0, 0, 0, 1, 1, 32'h10C, 1, DM_WORD, 1,
               0, 0, 0, 0);
    run_bundle(1, 0, 32'h108, 0, DM_WORD, 0, 0, 0, 0, 0, 0,
               0, -2, 0, 0);

    req2_valid = 1; req2_write = 0; req2_addr = 32'h104;
    req2_flags = DM_WORD;
    #1;
    chk("rw2_stall_idle", 128'(stall), 128'(1));
    @(posedge clock); #1;
    mem_ready = 1;
    @(posedge clock); #1;
    mem_ready = 0;
    chk("rw2_stall_wt2", 128'(stall), 128'(1));
    reset = 0; req2_valid = 0;
    @(posedge clock); #1;
    reset = 1; exp_err = 0;
    mem_rvalid = 1; mem_rdata = 32'hBAD0_BAD0;
    chk("rw2_stall", 128'(stall), 128'(0));
    chk("rw2_resp", 128'({resp1_valid, resp2_valid}), 128'(0));
    chk("rw2_err", 128'(err), 128'(0));
    @(posedge clock); #1;
    mem_rvalid = 0;
    chk("rw2_late_resp", 128'({resp1_valid, resp2_valid}), 128'(0));
    chk("rw2_late_req", 128'({mem_req, stall}), 128'(0));
    chk("rw2_rdata", 128'(resp2_rdata), 128'(0));
    @(posedge clock); #1;

    repeat (40) begin
      v1 = ($urandom % 5) != 0;
      v2 = ($urandom % 5) != 0;
      w1 = $urandom % 2 == 1;
      w2 = $urandom % 2 == 1;
      k2 = ($urandom % 4) == 0;
      a1 = 32'h100 + 32'($urandom_range(0, 7)) * 4;
      a2 = 32'h100 + 32'($urandom_range(0, 7)) * 4;
      run_bundle(v1, w1, a1, $urandom, 3'($urandom),
                 v2, w2, a2, $urandom, 3'($urandom), k2,
                 -1, -1, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
